// File: rtl/lh_pkg.sv
// lh_pkg: shared constants, event record and round-robin pick for the lighthouse event scheduler
package lh_pkg;
  localparam int LH_ID_W = 3;
  localparam int LH_TS_W = 32;
  localparam int LH_PW_W = 16;
  localparam int LH_MAX_N = 1 << LH_ID_W;
  typedef struct packed {
    logic [LH_ID_W-1:0] id;
    logic [LH_TS_W-1:0] ts;
    logic [LH_PW_W-1:0] pw;
  } lh_event_t;
  // First set bit of pend at or after ptr, wrapping within n channels; 0 when pend is empty.
  // Scanning offsets downward lets the smallest offset overwrite the result last.
  function automatic logic [LH_ID_W-1:0] lh_rr_pick(input logic [LH_MAX_N-1:0] pend,
                                                    input logic [LH_ID_W-1:0] ptr, input int n);
    int idx;
    lh_rr_pick = '0;
    for (int k = LH_MAX_N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && pend[idx[LH_ID_W-1:0]]) lh_rr_pick = idx[LH_ID_W-1:0];
    end
  endfunction
endpackage

// File: rtl/lh_event_scheduler_if.sv
// lh_event_scheduler_if: capture strobes into, and FIFO readout out of, the event scheduler
// master drives evt_valid/evt_ts/evt_pw and rd_ready; slave returns rd_valid and the FWFT head rd_data.
interface lh_event_scheduler_if
  import lh_pkg::*;
#(
  parameter int N_SENSORS = 5,
  parameter int TS_W = LH_TS_W,
  parameter int PW_W = LH_PW_W
);
  logic [N_SENSORS-1:0] evt_valid;
  logic [N_SENSORS*TS_W-1:0] evt_ts;
  logic [N_SENSORS*PW_W-1:0] evt_pw;
  logic rd_ready;
  logic rd_valid;
  logic [LH_ID_W+TS_W+PW_W-1:0] rd_data;
  modport master (output evt_valid, evt_ts, evt_pw, rd_ready, input rd_valid, rd_data);
  modport slave (input evt_valid, evt_ts, evt_pw, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/lh_event_fifo.sv
// lh_event_fifo: first-word-fall-through FIFO; head shows on dout whenever not empty, zero when empty
// Ports: clk, rst_n (async active-low); flush empties synchronously; push/din write the tail;
//        pop advances the head (ignored when empty); full, empty, fill report occupancy 0..DEPTH.
module lh_event_fifo #(
  parameter int W = 51,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = fill == '0;
  assign full = fill == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  // At full the entry being popped is exactly the one overwritten, so a same-edge push is safe.
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/lh_event_scheduler.sv
// lh_event_scheduler: round-robin arbiter moving per-channel lighthouse pulse captures into a shared FWFT FIFO
// Ports: clk, rst_n (async active-low); enable gates capture; flush clears pending slots, FIFO and pointer;
//        bus (slave) carries per-channel strobes/timestamps/widths in and the FIFO head/handshake out;
//        fill is FIFO occupancy; ovr holds sticky per-channel overruns, cleared by write-1 ovr_clr.
module lh_event_scheduler
  import lh_pkg::*;
#(
  parameter int N_SENSORS = 5,
  parameter int TS_W = LH_TS_W,
  parameter int PW_W = LH_PW_W,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic flush,
  lh_event_scheduler_if.slave bus,
  output logic [$clog2(DEPTH):0] fill,
  output logic [N_SENSORS-1:0] ovr,
  input  logic [N_SENSORS-1:0] ovr_clr
);
  localparam int W = LH_ID_W + TS_W + PW_W;
  logic [N_SENSORS-1:0] pend, cap, gmask, ovr_set;
  logic [LH_MAX_N-1:0] pend_x;
  logic [TS_W-1:0] slot_ts [N_SENSORS];
  logic [PW_W-1:0] slot_pw [N_SENSORS];
  logic [LH_ID_W-1:0] rr_ptr, gid;
  logic full, empty, pop, grant;
  logic [W-1:0] din;
  assign pop = bus.rd_ready & ~empty;
  assign cap = enable ? bus.evt_valid : '0;
  assign bus.rd_valid = ~empty;
  always_comb begin
    pend_x = '0;
    pend_x[N_SENSORS-1:0] = pend;
    gid = lh_rr_pick(pend_x, rr_ptr, N_SENSORS);
    grant = |pend & (~full | pop);
    for (int i = 0; i < N_SENSORS; i++) gmask[i] = grant && int'(gid) == i;
    // A channel granted this edge hands its old value to the FIFO, so a fresh strobe is no overrun.
    ovr_set = cap & pend & ~gmask & {N_SENSORS{~flush}};
    din = {gid, slot_ts[gid], slot_pw[gid]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      rr_ptr <= '0;
      ovr <= '0;
      for (int i = 0; i < N_SENSORS; i++) begin
        slot_ts[i] <= '0;
        slot_pw[i] <= '0;
      end
    end else begin
      ovr <= (ovr & ~ovr_clr) | ovr_set;
      if (flush) begin
        pend <= '0;
        rr_ptr <= '0;
      end else begin
        pend <= (pend & ~gmask) | cap;
        if (grant) rr_ptr <= (int'(gid) == N_SENSORS - 1) ? '0 : gid + LH_ID_W'(1);
        for (int i = 0; i < N_SENSORS; i++)
          if (cap[i]) begin
            slot_ts[i] <= bus.evt_ts[i*TS_W +: TS_W];
            slot_pw[i] <= bus.evt_pw[i*PW_W +: PW_W];
          end
      end
    end
  lh_event_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(grant),
    .pop(pop),
    .din(din),
    .dout(bus.rd_data),
    .full(full),
    .empty(empty),
    .fill(fill)
  );
endmodule

// File: tb/tb_lh_event_scheduler.sv
// tb_lh_event_scheduler: scoreboard bench; a queue-based reference model predicts FIFO contents,
// fill and overrun flags, and a negedge monitor compares them against the scheduler.
module tb_lh_event_scheduler;
  import lh_pkg::*;
  localparam int N = 5;
  localparam int TS_W = 32;
  localparam int PW_W = 16;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic rst_n = 0;
  logic enable = 0;
  logic flush = 0;
  logic [N-1:0] ovr;
  logic [N-1:0] ovr_clr = '0;
  logic [$clog2(DEPTH):0] fill;
  lh_event_scheduler_if #(.N_SENSORS(N), .TS_W(TS_W), .PW_W(PW_W)) bus ();
  lh_event_scheduler #(.N_SENSORS(N), .TS_W(TS_W), .PW_W(PW_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .flush(flush),
    .bus(bus),
    .fill(fill),
    .ovr(ovr),
    .ovr_clr(ovr_clr)
  );
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  lh_event_t exp_q[$];
  bit m_pend[N];
  logic [TS_W-1:0] m_ts[N];
  logic [PW_W-1:0] m_pw[N];
  int m_ptr = 0;
  logic [N-1:0] m_ovr = '0;
  bit mon_en = 0;
  bit mon_popped = 0;
  lh_event_t mon_e;
  logic [N-1:0] l_valid, l_clr;
  logic [N*TS_W-1:0] l_ts;
  logic [N*PW_W-1:0] l_pw;
  logic l_en, l_flush;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // The monitor retires the head whenever the consumer is ready and the model holds data.
  always @(negedge clk)
    if (mon_en) begin
      check("rd_valid", 64'(bus.rd_valid), 64'(exp_q.size() > 0));
      check("fill", 64'(fill), 64'(exp_q.size()));
      check("ovr", 64'(ovr), 64'(m_ovr));
      if (bus.rd_ready && !flush && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("rd_data", 64'(bus.rd_data), 64'(mon_e));
        mon_popped = 1;
      end
    end

  task automatic model_reset();
    exp_q.delete();
    foreach (m_pend[i]) begin
      m_pend[i] = 0;
      m_ts[i] = '0;
      m_pw[i] = '0;
    end
    m_ptr = 0;
    m_ovr = '0;
    mon_popped = 0;
  endtask

  // Applies the rules for one clock edge to the model, using the inputs that edge sampled.
  task automatic model_edge();
    bit pop;
    int size_pre;
    int g;
    logic [N-1:0] set;
    lh_event_t e;
    pop = mon_popped;
    mon_popped = 0;
    size_pre = exp_q.size() + int'(pop);
    g = -1;
    set = '0;
    if (l_flush) begin
      exp_q.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_ptr = 0;
      m_ovr = m_ovr & ~l_clr;
      return;
    end
    if (size_pre < DEPTH || pop)
      for (int k = 0; k < N && g < 0; k++)
        if (m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (g >= 0) begin
      e.id = LH_ID_W'(g);
      e.ts = m_ts[g];
      e.pw = m_pw[g];
      exp_q.push_back(e);
      m_pend[g] = 0;
      m_ptr = (g + 1) % N;
    end
    if (l_en)
      for (int i = 0; i < N; i++)
        if (l_valid[i]) begin
          if (m_pend[i]) set[i] = 1;
          m_ts[i] = l_ts[i*TS_W +: TS_W];
          m_pw[i] = l_pw[i*PW_W +: PW_W];
          m_pend[i] = 1;
        end
    m_ovr = (m_ovr & ~l_clr) | set;
  endtask

  task automatic step();
    l_valid = bus.evt_valid;
    l_ts = bus.evt_ts;
    l_pw = bus.evt_pw;
    l_en = enable;
    l_flush = flush;
    l_clr = ovr_clr;
    @(posedge clk);
    #1;
    model_edge();
    bus.evt_valid = '0;
    flush = 0;
    ovr_clr = '0;
  endtask

  task automatic strobe(input int ch, input logic [TS_W-1:0] ts, input logic [PW_W-1:0] pw);
    bus.evt_valid[ch] = 1'b1;
    bus.evt_ts[ch*TS_W +: TS_W] = ts;
    bus.evt_pw[ch*PW_W +: PW_W] = pw;
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    check("rst_fill", 64'(fill), 64'(0));
    check("rst_ovr", 64'(ovr), 64'(0));
    check("rst_rd_data", 64'(bus.rd_data), 64'(0));
  endtask

  // Asserts reset between edges and checks that outputs clear without waiting for a clock.
  task automatic async_reset();
    mon_en = 0;
    #3 rst_n = 0;
    #1 check_reset_outputs();
    model_reset();
    bus.evt_valid = '0;
    flush = 0;
    ovr_clr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mon_en = 1;
  endtask

  initial begin
    bus.evt_valid = '0;
    bus.evt_ts = '0;
    bus.evt_pw = '0;
    bus.rd_ready = 0;
    model_reset();
    #2 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    mon_en = 1;
    enable = 1;
    // single event on ch2, readable two edges after the strobe, then popped
    repeat (3) step();
    strobe(2, 32'h1000, 16'h40);
    step();
    step();
    step();
    bus.rd_ready = 1;
    step();
    bus.rd_ready = 0;
    step();
    // all channels at once from rr_ptr=0, drained in id order
    flush = 1;
    step();
    bus.rd_ready = 1;
    for (int ch = 0; ch < N; ch++) strobe(ch, $urandom, 16'($urandom));
    step();
    repeat (8) step();
    // fill to DEPTH without reading, then double strobe ch1 to force an overrun
    bus.rd_ready = 0;
    for (int c = 0; c < 20; c++) begin
      strobe(c % N, $urandom, 16'($urandom));
      step();
    end
    strobe(1, 32'hA, 16'h1);
    step();
    strobe(1, 32'hB, 16'h2);
    step();
    ovr_clr[1] = 1'b1;
    step();
    // pop and grant on the same edge while full
    bus.rd_ready = 1;
    step();
    bus.rd_ready = 0;
    step();
    bus.rd_ready = 1;
    repeat (25) step();
    ovr_clr = '1;
    step();
    // ch3 strobed again on the very edge its pending value is granted
    strobe(3, 32'h33, 16'h3);
    step();
    strobe(3, 32'h55, 16'h5);
    step();
    repeat (4) step();
    // flush with 7 queued entries and channels 0,2,4 pending, plus a strobe in the flush cycle
    bus.rd_ready = 0;
    flush = 1;
    step();
    for (int c = 0; c < 7; c++) begin
      strobe(0, 32'h100 + c, 16'(c));
      step();
    end
    step();
    strobe(0, 32'h200, 16'h20);
    strobe(2, 32'h202, 16'h22);
    strobe(4, 32'h204, 16'h24);
    step();
    flush = 1;
    strobe(0, 32'h300, 16'h30);
    step();
    step();
    // async reset in the middle of a burst
    bus.rd_ready = 1;
    for (int c = 0; c < 4; c++) begin
      for (int ch = 0; ch < N; ch++) strobe(ch, $urandom, 16'($urandom));
      step();
    end
    async_reset();
    // randomized traffic: a slow-consumer phase then a fast-consumer phase
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(9) != 0);
      bus.rd_ready = (c < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(2) == 0) strobe(ch, $urandom, 16'($urandom));
      flush = ($urandom_range(49) == 0);
      if ($urandom_range(7) == 0) ovr_clr = N'($urandom);
      step();
    end
    enable = 0;
    bus.rd_ready = 1;
    repeat (40) step();
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lh_event_scheduler.md
Name: lh_event_scheduler

Overview:
- Round-robin scheduler that shares one event FIFO among the lighthouse sensor pulse-timing channels.
- Each channel presents single-cycle "pulse captured" strobes carrying a timestamp and a pulse width. The scheduler buffers one pending event per channel and grants one channel per cycle into a shared FIFO.
- The FIFO is drained by the SPI register interface inside System. The scheduler sits between the per-sensor timers and the SPI readout.

Parameters:
- N_SENSORS, 5, number of lighthouse channels (1..8)
- TS_W, 32, timestamp width in TICK_CLK counts
- PW_W, 16, pulse-width field width
- DEPTH, 16, FIFO entries (power of two, ≥2)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- ENABLE  in  1  accept new events when high
- FLUSH  in  1  synchronous clear of pending slots, FIFO and pointer
- EVT_VALID  in  N_SENSORS  per-channel single-cycle capture strobe
- EVT_TS  in  N_SENSORS*TS_W  per-channel timestamp; channel i at [i*TS_W +: TS_W]
- EVT_PW  in  N_SENSORS*PW_W  per-channel pulse width, packed the same way
- RD_READY  in  1  consumer pops the head entry
- RD_VALID  out  1  FIFO not empty
- RD_DATA  out  3+TS_W+PW_W  head entry {id[2:0], ts, pw}; first-word fall-through
- FILL  out  $clog2(DEPTH)+1  current FIFO occupancy
- OVR  out  N_SENSORS  sticky per-channel overrun flags
- OVR_CLR  in  N_SENSORS  write-1-to-clear for OVR

Behaviour:
- Reset (RST_N low, async): pend=0, slots=0, rr_ptr=0, FIFO empty, RD_VALID=0, FILL=0, OVR=0, RD_DATA=0.
- Capture: at an edge where EVT_VALID[i]=1 and ENABLE=1, slot i loads {ts, pw} and pend[i]=1.
  - EVT_VALID is ignored while ENABLE=0; pending slots still drain.
- Overrun: a new event on channel i while pend[i]=1 and channel i is not granted that cycle → overwrite the slot (newest wins) and set OVR[i]=1.
  - If channel i is granted in the same cycle: the old value goes to the FIFO, the new value loads, pend[i] stays 1, no overrun.
- Grant condition: any pend bit set and (FILL<DEPTH, or FILL==DEPTH with pop this cycle).
  - Grant goes to the first set pend bit searching from rr_ptr upward with wrap.
  - On grant: FIFO writes {grant_id, slot.ts, slot.pw}; pend[grant] clears unless reloaded the same cycle; rr_ptr ← (grant+1) mod N_SENSORS.
  - With no grant, rr_ptr holds.
- Full: no grant, pend bits hold. Back-pressure is visible only as OVR on subsequent events.
- Latency: strobe sampled at edge k → FIFO write at edge k+1 → RD_VALID and RD_DATA valid after edge k+1. Minimum 2 edges, strobe to readable.
- Read: pop at an edge with RD_VALID & RD_READY. RD_READY while empty is ignored; FILL never underflows.
- Simultaneous push and pop: FILL unchanged. This is allowed at full (pop frees the entry written the same edge) and at empty (no pop occurs; push only).
- FILL range 0..DEPTH. Pointers wrap modulo DEPTH.
- OVR: set has priority over OVR_CLR in the same cycle.
- FLUSH: at the edge, pend=0, FIFO emptied, rr_ptr=0.
  - Events strobed in the same cycle are discarded.
  - OVR is unaffected.
  - FLUSH has priority over capture, grant and pop.
- Reset asserted mid-operation clears everything immediately (async). Deassertion is synchronized externally; the first edge after release behaves as idle.
- The id field is 3 bits fixed; unused upper values are never produced.

Decomposition:
- Package lh_pkg:
  - LH_ID_W=3
  - constants TS_W and PW_W defaults
  - typedef lh_event_t {id, ts, pw}
  - function lh_rr_pick(pend, ptr) returning the grant index
- Sub-module lh_event_fifo: synchronous FWFT FIFO, DEPTH×width, ports push/pop/full/empty/fill/flush, async active-low reset.
- The scheduler holds the slots, pend, OVR, rr_ptr and grant logic.

Test Plan:
- Single event, ch2 ts=0x1000 pw=0x40 at cycle 10 → RD_VALID high after cycle 11 edge, RD_DATA={2,0x00001000,0x0040}, FILL=1; pop → FILL=0.
- All 5 channels strobe in one cycle with rr_ptr=0, RD_READY=1 → FIFO order ids 0,1,2,3,4 on consecutive cycles; rr_ptr ends at 0; OVR=0.
- DEPTH=16 filled with RD_READY=0, ch1 strobed twice (ts=0xA then 0xB) → OVR[1]=1, one entry ts=0xB after first pop; OVR_CLR[1] → OVR[1]=0.
- Full FIFO with pop and grant on the same edge → FILL stays 16; popped entry is the old head; new entry is at tail.
- ch3 pending and granted the same cycle a new strobe ts=0x55 arrives → old value in FIFO, pend[3]=1 with ts=0x55, OVR[3]=0.
- FLUSH with FILL=7 and pend=5'b10101, plus a strobe on ch0 → FILL=0, pend=0, RD_VALID=0, OVR unchanged; async RST_N pulse mid-burst → all outputs 0 immediately.
